// File: rtl/eco32_core_lsu_dcu_pt_fill_if.sv
// Bundle of refill, flush, memory-fetch and table-write signals for the
// page descriptor table fill controller. The controller uses the slave view;
// the requester/memory/table side uses the master view.
interface eco32_core_lsu_dcu_pt_fill_if #(
    parameter int PAGE_ADDR_WIDTH = 5
);
    // Refill request from the LSU miss path
    logic                       req_stb;
    logic                       req_tid;
    logic [PAGE_ADDR_WIDTH-1:0] req_page;
    logic                       req_ack;

    // Per-thread flush request
    logic                       flush_stb;
    logic                       flush_tid;
    logic                       flush_ack;

    // Descriptor fetch port
    logic                       mem_req;
    logic                       mem_tid;
    logic [PAGE_ADDR_WIDTH-1:0] mem_page;
    logic                       mem_ack;
    logic                       mem_rsp_stb;
    logic                       mem_rsp_err;
    logic [38:0]                mem_rsp_descriptor;

    // Table write port
    logic                       wr_ena;
    logic                       wr_tid;
    logic [PAGE_ADDR_WIDTH-1:0] wr_page;
    logic [38:0]                wr_descriptor;

    // Status
    logic                       busy;
    logic                       done_stb;
    logic                       done_err;

    modport slave (
        input  req_stb, req_tid, req_page,
        input  flush_stb, flush_tid,
        input  mem_ack, mem_rsp_stb, mem_rsp_err, mem_rsp_descriptor,
        output req_ack, flush_ack,
        output mem_req, mem_tid, mem_page,
        output wr_ena, wr_tid, wr_page, wr_descriptor,
        output busy, done_stb, done_err
    );

    modport master (
        output req_stb, req_tid, req_page,
        output flush_stb, flush_tid,
        output mem_ack, mem_rsp_stb, mem_rsp_err, mem_rsp_descriptor,
        input  req_ack, flush_ack,
        input  mem_req, mem_tid, mem_page,
        input  wr_ena, wr_tid, wr_page, wr_descriptor,
        input  busy, done_stb, done_err
    );
endinterface

// File: rtl/eco32_core_lsu_dcu_pt_fill.sv
// Write-side controller for the data-cache-way page descriptor table.
// Refills one (thread, page) entry from a request/response memory port, or
// sweeps every page of one thread to the all-zero (invalid) descriptor.
// Every output comes straight from a register; the next-state logic computes
// the value each output must show in the following cycle.
module eco32_core_lsu_dcu_pt_fill #(
    parameter int PAGE_ADDR_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    eco32_core_lsu_dcu_pt_fill_if.slave bus
);
    localparam int                         DESC_WIDTH = 39;
    localparam logic [PAGE_ADDR_WIDTH-1:0] LAST_PAGE  = '1;
    localparam logic [PAGE_ADDR_WIDTH-1:0] PAGE_ONE   = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_WRITE,
        ST_FLUSH
    } state_t;

    state_t state_reg, state_next;

    // Latched operation context
    logic                       tid_reg, tid_next;
    logic [PAGE_ADDR_WIDTH-1:0] page_reg, page_next;
    logic [PAGE_ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic [PAGE_ADDR_WIDTH-1:0] cnt_inc;

    // Output registers
    logic                       req_ack_reg, req_ack_next;
    logic                       flush_ack_reg, flush_ack_next;
    logic                       mem_req_reg, mem_req_next;
    logic                       mem_tid_reg, mem_tid_next;
    logic [PAGE_ADDR_WIDTH-1:0] mem_page_reg, mem_page_next;
    logic                       wr_ena_reg, wr_ena_next;
    logic                       wr_tid_reg, wr_tid_next;
    logic [PAGE_ADDR_WIDTH-1:0] wr_page_reg, wr_page_next;
    logic [DESC_WIDTH-1:0]      wr_descriptor_reg, wr_descriptor_next;
    logic                       busy_reg, busy_next;
    logic                       done_stb_reg, done_stb_next;
    logic                       done_err_reg, done_err_next;

    // Set when this cycle's memory response should become the table write
    logic                       take_rsp;

    assign cnt_inc = cnt_reg + PAGE_ONE;

    // State register; reset abandons whatever operation is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Context and output registers; all outputs read 0 out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tid_reg           <= 1'b0;
            page_reg          <= '0;
            cnt_reg           <= '0;
            req_ack_reg       <= 1'b0;
            flush_ack_reg     <= 1'b0;
            mem_req_reg       <= 1'b0;
            mem_tid_reg       <= 1'b0;
            mem_page_reg      <= '0;
            wr_ena_reg        <= 1'b0;
            wr_tid_reg        <= 1'b0;
            wr_page_reg       <= '0;
            wr_descriptor_reg <= '0;
            busy_reg          <= 1'b0;
            done_stb_reg      <= 1'b0;
            done_err_reg      <= 1'b0;
        end else begin
            tid_reg           <= tid_next;
            page_reg          <= page_next;
            cnt_reg           <= cnt_next;
            req_ack_reg       <= req_ack_next;
            flush_ack_reg     <= flush_ack_next;
            mem_req_reg       <= mem_req_next;
            mem_tid_reg       <= mem_tid_next;
            mem_page_reg      <= mem_page_next;
            wr_ena_reg        <= wr_ena_next;
            wr_tid_reg        <= wr_tid_next;
            wr_page_reg       <= wr_page_next;
            wr_descriptor_reg <= wr_descriptor_next;
            busy_reg          <= busy_next;
            done_stb_reg      <= done_stb_next;
            done_err_reg      <= done_err_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next         = state_reg;
        tid_next           = tid_reg;
        page_next          = page_reg;
        cnt_next           = cnt_reg;
        req_ack_next       = 1'b0;
        flush_ack_next     = 1'b0;
        mem_req_next       = mem_req_reg;
        mem_tid_next       = mem_tid_reg;
        mem_page_next      = mem_page_reg;
        wr_ena_next        = 1'b0;
        wr_tid_next        = wr_tid_reg;
        wr_page_next       = wr_page_reg;
        wr_descriptor_next = wr_descriptor_reg;
        done_stb_next      = 1'b0;
        done_err_next      = 1'b0;
        take_rsp           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.flush_stb) begin
                    // Flush wins over a simultaneous refill; page 0 is
                    // written in the very first FLUSH cycle.
                    flush_ack_next     = 1'b1;
                    tid_next           = bus.flush_tid;
                    cnt_next           = '0;
                    wr_ena_next        = 1'b1;
                    wr_tid_next        = bus.flush_tid;
                    wr_page_next       = '0;
                    wr_descriptor_next = '0;
                    state_next         = ST_FLUSH;
                end else if (bus.req_stb) begin
                    req_ack_next  = 1'b1;
                    tid_next      = bus.req_tid;
                    page_next     = bus.req_page;
                    mem_req_next  = 1'b1;
                    mem_tid_next  = bus.req_tid;
                    mem_page_next = bus.req_page;
                    state_next    = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // Request fields hold until the memory accepts it; a response
                // arriving in the same cycle as the accept is not lost.
                if (bus.mem_ack) begin
                    mem_req_next = 1'b0;
                    if (bus.mem_rsp_stb) begin
                        take_rsp   = 1'b1;
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (bus.mem_rsp_stb) begin
                    take_rsp   = 1'b1;
                    state_next = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // The write and done pulse are already on the outputs
                state_next = ST_IDLE;
            end

            ST_FLUSH: begin
                // wr_page_reg currently shows cnt_reg; stop once the last
                // page has been written so the counter never wraps.
                if (cnt_reg == LAST_PAGE) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next           = cnt_inc;
                    wr_ena_next        = 1'b1;
                    wr_tid_next        = tid_reg;
                    wr_page_next       = cnt_inc;
                    wr_descriptor_next = '0;
                    done_stb_next      = (cnt_inc == LAST_PAGE);
                end
            end

            default: begin
                state_next   = ST_IDLE;
                mem_req_next = 1'b0;
            end
        endcase

        // A failed fetch still writes, but with the invalid descriptor
        if (take_rsp) begin
            wr_ena_next        = 1'b1;
            wr_tid_next        = tid_reg;
            wr_page_next       = page_reg;
            wr_descriptor_next = bus.mem_rsp_err ? '0 : bus.mem_rsp_descriptor;
            done_stb_next      = 1'b1;
            done_err_next      = bus.mem_rsp_err;
        end

        busy_next = (state_next != ST_IDLE);
    end

    assign bus.req_ack       = req_ack_reg;
    assign bus.flush_ack     = flush_ack_reg;
    assign bus.mem_req       = mem_req_reg;
    assign bus.mem_tid       = mem_tid_reg;
    assign bus.mem_page      = mem_page_reg;
    assign bus.wr_ena        = wr_ena_reg;
    assign bus.wr_tid        = wr_tid_reg;
    assign bus.wr_page       = wr_page_reg;
    assign bus.wr_descriptor = wr_descriptor_reg;
    assign bus.busy          = busy_reg;
    assign bus.done_stb      = done_stb_reg;
    assign bus.done_err      = done_err_reg;
endmodule

// File: tb/tb_eco32_core_lsu_dcu_pt_fill.sv
// Directed bench for the page descriptor table fill controller. Expected
// table writes are queued when stimulus is driven and popped by a monitor
// whenever the DUT asserts wr_ena.
module tb_eco32_core_lsu_dcu_pt_fill;
    localparam int PW    = 5;
    localparam int PAGES = 1 << PW;

    typedef struct packed {
        logic          tid;
        logic [PW-1:0] page;
        logic [38:0]   desc;
        logic          done;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    eco32_core_lsu_dcu_pt_fill_if #(.PAGE_ADDR_WIDTH(PW)) bus ();

    eco32_core_lsu_dcu_pt_fill #(.PAGE_ADDR_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every table write must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.wr_ena === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {63'd0, bus.wr_ena}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_tid",   {63'd0, bus.wr_tid},    {63'd0, e.tid});
                check("wr_page",  {59'd0, bus.wr_page},   {59'd0, e.page});
                check("wr_desc",  {25'd0, bus.wr_descriptor}, {25'd0, e.desc});
                check("done_stb", {63'd0, bus.done_stb},  {63'd0, e.done});
                check("done_err", {63'd0, bus.done_err},  {63'd0, e.err});
                $display("write tid=%0d page=%0d desc=%h done=%0d err=%0d",
                         bus.wr_tid, bus.wr_page, bus.wr_descriptor, bus.done_stb, bus.done_err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    // Refill with ack_dly cycles of back-pressure and the response rsp_dly
    // cycles after the accept (0 = same cycle as mem_ack). Entered and left
    // at a negedge.
    task automatic refill(input logic tid, input logic [PW-1:0] page, input int ack_dly,
                          input int rsp_dly, input logic [38:0] desc, input logic err);
        int n;
        exp_t e;
        bus.req_stb  = 1'b1;
        bus.req_tid  = tid;
        bus.req_page = page;
        e.tid  = tid;
        e.page = page;
        e.desc = err ? 39'd0 : desc;
        e.done = 1'b1;
        e.err  = err;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ack !== 1'b1 && n < 100);
        check("req_ack", {63'd0, bus.req_ack}, 64'd1);
        check("mem_req_on", {63'd0, bus.mem_req}, 64'd1);
        check("mem_tid", {63'd0, bus.mem_tid}, {63'd0, tid});
        check("mem_page", {59'd0, bus.mem_page}, {59'd0, page});
        bus.req_stb = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            check("bp_mem_req", {63'd0, bus.mem_req}, 64'd1);
            check("bp_mem_tid", {63'd0, bus.mem_tid}, {63'd0, tid});
            check("bp_mem_page", {59'd0, bus.mem_page}, {59'd0, page});
            check("bp_no_wr", {63'd0, bus.wr_ena}, 64'd0);
        end
        bus.mem_ack = 1'b1;
        if (rsp_dly == 0) begin
            bus.mem_rsp_stb        = 1'b1;
            bus.mem_rsp_err        = err;
            bus.mem_rsp_descriptor = desc;
        end
        @(negedge clk);
        bus.mem_ack     = 1'b0;
        bus.mem_rsp_stb = 1'b0;
        check("mem_req_drop", {63'd0, bus.mem_req}, 64'd0);
        check("req_ack_pulse", {63'd0, bus.req_ack}, 64'd0);
        if (rsp_dly > 0) begin
            for (int i = 1; i < rsp_dly; i++) begin
                @(negedge clk);
                check("wait_no_wr", {63'd0, bus.wr_ena}, 64'd0);
            end
            bus.mem_rsp_stb        = 1'b1;
            bus.mem_rsp_err        = err;
            bus.mem_rsp_descriptor = desc;
            @(negedge clk);
            bus.mem_rsp_stb = 1'b0;
        end
        check("write_wr_ena", {63'd0, bus.wr_ena}, 64'd1);
        check("write_done", {63'd0, bus.done_stb}, 64'd1);
        check("write_busy", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        check("after_busy", {63'd0, bus.busy}, 64'd0);
        check("after_done", {63'd0, bus.done_stb}, 64'd0);
        check("after_wr_ena", {63'd0, bus.wr_ena}, 64'd0);
        $display("refill tid=%0d page=%0d ack_dly=%0d rsp_dly=%0d err=%0d complete", tid, page, ack_dly, rsp_dly, err);
    endtask

    // Flush one thread: 32 consecutive writes, then nothing more
    task automatic flush(input logic tid);
        int n;
        exp_t e;
        bus.flush_stb = 1'b1;
        bus.flush_tid = tid;
        for (int p = 0; p < PAGES; p++) begin
            e.tid  = tid;
            e.page = p[PW-1:0];
            e.desc = 39'd0;
            e.done = (p == PAGES - 1);
            e.err  = 1'b0;
            exp_q.push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.flush_ack !== 1'b1 && n < 100);
        check("flush_ack", {63'd0, bus.flush_ack}, 64'd1);
        bus.flush_stb = 1'b0;
        for (int p = 0; p < PAGES; p++) begin
            if (p > 0) @(negedge clk);
            check("flush_wr_ena", {63'd0, bus.wr_ena}, 64'd1);
            check("flush_busy", {63'd0, bus.busy}, 64'd1);
            check("flush_no_req_ack", {63'd0, bus.req_ack}, 64'd0);
        end
        @(negedge clk);
        check("flush_no_extra_wr", {63'd0, bus.wr_ena}, 64'd0);
        check("flush_busy_end", {63'd0, bus.busy}, 64'd0);
        check("flush_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("flush tid=%0d complete", tid);
    endtask

    initial begin
        bus.req_stb            = 1'b0;
        bus.req_tid            = 1'b0;
        bus.req_page           = '0;
        bus.flush_stb          = 1'b0;
        bus.flush_tid          = 1'b0;
        bus.mem_ack            = 1'b0;
        bus.mem_rsp_stb        = 1'b0;
        bus.mem_rsp_err        = 1'b0;
        bus.mem_rsp_descriptor = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ack", {63'd0, bus.req_ack}, 64'd0);
        check("rst_flush_ack", {63'd0, bus.flush_ack}, 64'd0);
        check("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        check("rst_wr_ena", {63'd0, bus.wr_ena}, 64'd0);
        check("rst_wr_desc", {25'd0, bus.wr_descriptor}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done_stb}, 64'd0);
        check("rst_done_err", {63'd0, bus.done_err}, 64'd0);
        $display("reset state checked");
        @(negedge clk);

        // Basic refill, minimum latency, and same-cycle ack+response
        refill(1'b1, 5'd5, 1, 2, 39'h12_3456_789A, 1'b0);
        refill(1'b0, 5'd3, 0, 1, 39'h01_0203_0405, 1'b0);
        refill(1'b1, 5'd31, 0, 0, 39'h55_AAAA_5555, 1'b0);

        // Failed fetch writes the invalid descriptor
        refill(1'b0, 5'd7, 1, 2, 39'h7F_FFFF_FFFF, 1'b1);

        // Full flush of thread 0
        flush(1'b0);

        // Flush and refill requested together: flush first, then the refill
        bus.req_stb  = 1'b1;
        bus.req_tid  = 1'b1;
        bus.req_page = 5'd12;
        flush(1'b1);
        refill(1'b1, 5'd12, 0, 1, 39'h3C_0F0F_F0F0, 1'b0);

        // Back-pressure on the fetch port
        refill(1'b0, 5'd20, 10, 3, 39'h6E_DCBA_9876, 1'b0);

        // Stray response while idle is ignored
        bus.mem_rsp_stb        = 1'b1;
        bus.mem_rsp_descriptor = 39'h11_1111_1111;
        @(negedge clk);
        bus.mem_rsp_stb = 1'b0;
        check("idle_rsp_no_wr", {63'd0, bus.wr_ena}, 64'd0);
        check("idle_rsp_busy", {63'd0, bus.busy}, 64'd0);
        $display("stray idle response checked");

        // Reset during WAIT, then a late response
        begin
            int n;
            bus.req_stb  = 1'b1;
            bus.req_tid  = 1'b0;
            bus.req_page = 5'd9;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.req_ack !== 1'b1 && n < 100);
            check("rw_req_ack", {63'd0, bus.req_ack}, 64'd1);
            bus.req_stb = 1'b0;
            bus.mem_ack = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            check("rw_in_wait_busy", {63'd0, bus.busy}, 64'd1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("rw_busy_after_rst", {63'd0, bus.busy}, 64'd0);
            check("rw_mem_req_after_rst", {63'd0, bus.mem_req}, 64'd0);
            bus.mem_rsp_stb        = 1'b1;
            bus.mem_rsp_descriptor = 39'h22_2222_2222;
            @(negedge clk);
            bus.mem_rsp_stb = 1'b0;
            check("rw_late_rsp_no_wr", {63'd0, bus.wr_ena}, 64'd0);
            check("rw_late_rsp_no_done", {63'd0, bus.done_stb}, 64'd0);
            @(negedge clk);
            check("rw_late_rsp_no_wr2", {63'd0, bus.wr_ena}, 64'd0);
            check("rw_busy_idle", {63'd0, bus.busy}, 64'd0);
            $display("reset during wait checked");
        end
        refill(1'b1, 5'd9, 2, 1, 39'h40_0000_0001, 1'b0);

        repeat (2) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eco32_core_lsu_dcu_pt_fill.md
Name: eco32_core_lsu_dcu_pt_fill

Overview:
Write-side controller for the data-cache-way page descriptor table. It accepts descriptor refill requests (thread, page) from the LSU miss path and fetches the 39-bit descriptor over a request/response memory port. It drives the table's write port (wr_ena/wr_tid/wr_page/wr_descriptor) and also performs per-thread flushes, sweeping every page of one thread to an all-zero (invalid) descriptor.

Parameters:
PAGE_ADDR_WIDTH, 5, page index width; must match the table instance; 2**PAGE_ADDR_WIDTH pages per thread.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_stb  in  1  refill request; held until req_ack
req_tid  in  1  thread of request
req_page  in  PAGE_ADDR_WIDTH  page of request
req_ack  out  1  one-cycle accept pulse
flush_stb  in  1  flush request; held until flush_ack
flush_tid  in  1  thread to flush
flush_ack  out  1  one-cycle accept pulse
mem_req  out  1  descriptor fetch request; held until mem_ack
mem_tid  out  1  fetch thread
mem_page  out  PAGE_ADDR_WIDTH  fetch page
mem_ack  in  1  fetch accepted
mem_rsp_stb  in  1  descriptor response valid, single cycle
mem_rsp_err  in  1  fetch failed
mem_rsp_descriptor  in  39  fetched descriptor
wr_ena  out  1  table write enable
wr_tid  out  1  table write thread
wr_page  out  PAGE_ADDR_WIDTH  table write page
wr_descriptor  out  39  table write data
busy  out  1  state is not IDLE
done_stb  out  1  operation complete pulse
done_err  out  1  qualifies done_stb: refill failed

Behaviour:
- All outputs are registered. On reset, every output is 0 and the state is IDLE.
- States: IDLE, FETCH, WAIT, WRITE, FLUSH.
- IDLE:
  - flush_stb has priority over req_stb when both are high.
  - On flush_stb: pulse flush_ack, latch flush_tid, clear the page counter to 0, go to FLUSH.
  - Otherwise on req_stb: pulse req_ack, latch tid/page, assert mem_req with mem_tid/mem_page, go to FETCH.
  - Stb inputs are sampled only in IDLE; an ack is issued at most once per operation.
- FETCH:
  - mem_req, mem_tid and mem_page stay stable until mem_ack is seen.
  - mem_req drops the cycle after mem_ack; go to WAIT.
  - If mem_rsp_stb coincides with mem_ack, the response is captured and the FSM goes directly to WRITE.
- WAIT: on mem_rsp_stb, capture the descriptor and err, go to WRITE. There is no timeout.
- WRITE (one cycle):
  - wr_ena=1, wr_tid/wr_page = latched request.
  - wr_descriptor = captured descriptor, or 39'd0 if err.
  - done_stb=1 and done_err=err in the same cycle.
  - Next state is IDLE. The table entry is readable combinationally from the cycle after WRITE.
- FLUSH:
  - Each cycle: wr_ena=1, wr_tid=latched tid, wr_page=counter, wr_descriptor=0; the counter increments.
  - At counter = 2**PAGE_ADDR_WIDTH-1, done_stb is asserted with the final write; return to IDLE.
  - The counter must not wrap into an extra write. A flush takes exactly 2**PAGE_ADDR_WIDTH write cycles.
- mem_rsp_stb outside FETCH/WAIT is ignored. wr_ena is never asserted outside WRITE/FLUSH.
- wr_* fields are don't-care when wr_ena=0 but must not glitch with wr_ena=1.
- busy=1 in every non-IDLE state.
- Minimum latency for a refill accepted at cycle 0 with zero-wait memory: mem_req high at cycle 1, mem_ack at 1, rsp at 2, WRITE at 3, IDLE at 4.
- Reset in any state:
  - Abandons the operation: no pending write, mem_req deasserts, back to IDLE.
  - A late mem_rsp_stb after reset is ignored.
  - A flush interrupted by reset leaves pages partially cleared; this is legal.

Test Plan:
- Refill: req tid=1 page=5 with mem acking in 1 cycle and responding with 39'h12_3456_789A 2 cycles later -> one wr_ena pulse with tid=1, page=5 and that data; done_stb=1, done_err=0; busy low the next cycle.
- Error refill: rsp_err=1 with descriptor 39'h7F_FFFF_FFFF -> write of 39'd0 to the requested page, done_err=1.
- Flush tid=0 with PAGE_ADDR_WIDTH=5 -> exactly 32 consecutive wr_ena cycles, pages 0..31, data 0; done_stb on page 31; no 33rd write.
- Simultaneous flush_stb and req_stb in IDLE -> flush_ack first, the full sweep, then req_ack, and the refill proceeds.
- Back-pressure: mem_ack held low for 10 cycles -> mem_req, mem_tid and mem_page stable throughout; no wr_ena.
- Reset during WAIT followed by mem_rsp_stb -> no wr_ena and no done_stb; a new request is then serviced normally.
